// File: rtl/cache_mem_arbiter_if.sv
// Line-transaction bus between the two L1 refill paths, the arbiter and the
// backing RAM controller.
//
// Handshake rules, in one place:
//  - ic_valid / dc_valid rise with a request and stay high through the cycle
//    in which the matching done pulses. From the cycle after done they are
//    low or carry a new request. Address/data are only sampled on the grant
//    edge.
//  - ic_done / dc_done are single-cycle pulses; rdata is valid in that cycle
//    and holds until the next read completes for the same requester.
//  - mem_valid, mem_rw, mem_addr and mem_wdata stay constant from the cycle
//    mem_valid rises until the edge where mem_ready = 1. mem_ready is a
//    one-cycle completion strobe carrying mem_rdata for reads.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              ic_valid;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_valid;
  logic              dc_rw;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_done;
  logic [LINE_W-1:0] dc_rdata;

  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport slave (
    input  ic_valid, ic_addr, dc_valid, dc_rw, dc_addr, dc_wdata,
    input  mem_rdata, mem_ready,
    output ic_done, ic_rdata, dc_done, dc_rdata,
    output mem_valid, mem_rw, mem_addr, mem_wdata
  );

  // Caches + RAM controller side
  modport master (
    output ic_valid, ic_addr, dc_valid, dc_rw, dc_addr, dc_wdata,
    output mem_rdata, mem_ready,
    input  ic_done, ic_rdata, dc_done, dc_rdata,
    input  mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single line-wide RAM port between the icache refill path and
// the dcache refill/writeback path. One transaction at a time, round-robin
// on ties, registered and stable request signals toward RAM.
module cache_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic                 clk,
  input  logic                 RESET,
  cache_mem_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_t state;
  state_t state_nxt;
  logic   last_grant_d;  // 1 when the dcache owns (or last owned) the port
  logic   grant_i;
  logic   grant_d;

  // Next-state and grant decision; requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ic_valid && (!bus.dc_valid || last_grant_d)) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (bus.dc_valid) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin pointer, updated on the grant edge
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_i)      last_grant_d <= 1'b0;
      else if (grant_d) last_grant_d <= 1'b1;
    end
  end

  // RAM request registers: loaded on grant, frozen until mem_ready
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      bus.mem_valid <= 1'b0;
      bus.mem_rw    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (grant_i) begin
      bus.mem_valid <= 1'b1;
      bus.mem_rw    <= 1'b0;
      bus.mem_addr  <= bus.ic_addr & ALIGN_MASK;
      bus.mem_wdata <= '0;
    end else if (grant_d) begin
      bus.mem_valid <= 1'b1;
      bus.mem_rw    <= bus.dc_rw;
      bus.mem_addr  <= bus.dc_addr & ALIGN_MASK;
      bus.mem_wdata <= bus.dc_wdata;
    end else if ((state == BUSY_I || state == BUSY_D) && bus.mem_ready) begin
      bus.mem_valid <= 1'b0;
    end
  end

  // Per-requester read-line registers; writebacks leave them untouched
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      bus.ic_rdata <= '0;
      bus.dc_rdata <= '0;
    end else if (bus.mem_ready) begin
      if (state == BUSY_I) bus.ic_rdata <= bus.mem_rdata;
      if (state == BUSY_D && !bus.mem_rw) bus.dc_rdata <= bus.mem_rdata;
    end
  end

  // The done pulse goes to whoever holds the grant pointer during DONE
  assign bus.ic_done = (state == DONE) && !last_grant_d;
  assign bus.dc_done = (state == DONE) &&  last_grant_d;
  assign dbg_state   = state;

endmodule
